fetch_controller: RTL and testbench

Sequencer for the instruction-fetch path: owns the program counter, drives the instruction-memory read address, and buffers fetched `{instruction, pc}` words in a small queue toward decode with a valid/ready handshake. It applies branch redirects from execute, freezes on hazard-unit stalls, and halts fetch on a halt word. It sits between the instruction memory (combinational read) and the IF/ID boundary. The execute redirect bus and the 24-bit fetch word packing are the same as the existing fetch path uses.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_controller.sv | 96 +++++++++
 tb/tb_fetch_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch path: FSM states,
// the halt word, redirect bus bit positions and fetch-word field layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  localparam int REDIRECT_TAKEN_BIT  = 11;
  localparam int REDIRECT_TARGET_MSB = 7;
  localparam int REDIRECT_TARGET_LSB = 0;

  localparam int FW_PC_LSB    = 0;
  localparam int FW_PC_MSB    = 7;
  localparam int FW_INSTR_LSB = 8;
  localparam int FW_INSTR_MSB = 23;
  localparam int FW_PC_W      = FW_PC_MSB - FW_PC_LSB + 1;
  localparam int FW_INSTR_W   = FW_INSTR_MSB - FW_INSTR_LSB + 1;
  localparam int FETCH_W      = FW_INSTR_MSB + 1;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch words between the PC sequencer and decode.
// Clear takes priority over push/pop; push while full is accepted only with a pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads instruction memory and
// queues {instr, pc} words toward decode; handles redirect, stall and halt.
//
//   state | meaning
//   BOOT  | first cycle after reset, no fetch
//   RUN   | fetching one word per cycle when not stalled and queue has room
//   HALT  | halt word fetched; PC frozen until a redirect, queue drains
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        redirect_bus,
  input  logic               stall,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [FETCH_W-1:0] if_output,
  output logic [7:0]         redirect_count
);

  fetch_state_t          state;
  logic [ADDR_W-1:0]     pc;
  logic                  redirect;
  logic [ADDR_W-1:0]     target;
  logic                  deq;
  logic                  enq;
  logic                  is_halt;
  logic [FETCH_W-1:0]    entry;
  logic [$clog2(DEPTH):0] q_count;
  logic                  q_full;
  logic                  q_empty;

  assign imem_addr = pc;
  assign redirect  = redirect_bus[REDIRECT_TAKEN_BIT];
  assign target    = ADDR_W'(redirect_bus[REDIRECT_TARGET_MSB:REDIRECT_TARGET_LSB]);
  assign if_valid  = (q_count != '0);
  assign deq       = if_ready && !q_empty;
  assign is_halt   = (imem_data == INSTR_W'(HALT_WORD));
  // A dequeue in the same cycle frees a slot, so a full queue still accepts.
  assign enq       = (state == ST_RUN) && !redirect && !stall && (!q_full || deq);

  always_comb begin
    entry = '0;
    entry[FW_INSTR_MSB:FW_INSTR_LSB] = FW_INSTR_W'(imem_data);
    entry[FW_PC_MSB:FW_PC_LSB]       = FW_PC_W'(pc);
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (enq),
    .pop   (deq),
    .wdata (entry),
    .rdata (if_output),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BOOT;
      pc             <= ADDR_W'(RESET_PC);
      redirect_count <= '0;
    end else if (redirect) begin
      state <= ST_RUN;
      pc    <= target;
      if (redirect_count != 8'hFF) redirect_count <= redirect_count + 8'd1;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (enq) begin
            if (is_halt) state <= ST_HALT;
            else         pc    <= pc + ADDR_W'(PC_STEP);
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected fetch words are queued when
// a fetch stream is started and checked against each completed handshake.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] redirect_bus;
  logic        stall;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [23:0] if_output;
  logic [7:0]  redirect_count;

  logic [15:0] mem [256];
  logic [23:0] sb [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          found;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_bus   (redirect_bus),
    .stall          (stall),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_output      (if_output),
    .redirect_count (redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] word(input logic [7:0] a);
    return {mem[a], a};
  endfunction

  function automatic logic [15:0] rb_to(input logic [7:0] t);
    return {4'h0, 1'b1, 3'b000, t};
  endfunction

  task automatic push_stream(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(word(start + 8'(i)));
  endtask

  // One cycle: drive inputs at the negedge, score any handshake, advance.
  task automatic cyc(input logic rdy, input logic stl, input logic [15:0] rb);
    logic [31:0] exp;
    if_ready     = rdy;
    stall        = stl;
    redirect_bus = rb;
    #1;
    if (if_valid && if_ready) begin
      if (sb.size() > 0) exp = {8'h0, sb.pop_front()};
      else               exp = 32'hFFFF_FFFF;
      chk("deq_word", {8'h0, if_output}, exp);
    end
    if (rb[11] || rst) sb.delete();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5 ^ 8'(i), 8'(i)};
    mem[8'h05] = 16'hFFFF;
    mem[8'h24] = 16'hFFFF;
    mem[8'h2F] = 16'hFFFF;
    mem[8'h45] = 16'hFFFF;

    rst = 1'b1; if_ready = 1'b1; stall = 1'b0; redirect_bus = '0;
    cyc(1, 0, 16'h0);
    cyc(1, 0, 16'h0);

    // reset release and boot latency, then streaming to the halt word at 0x05
    rst = 1'b0;
    push_stream(8'h00, 6);
    chk("rst_valid", if_valid, 0);
    chk("rst_out", if_output, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_rcnt", redirect_count, 0);
    cyc(1, 0, 16'h0);
    chk("boot_valid", if_valid, 0);
    chk("boot_pc", imem_addr, 0);
    cyc(1, 0, 16'h0);
    chk("first_valid", if_valid, 1);
    chk("first_pc", imem_addr, 1);
    repeat (10) cyc(1, 0, 16'h0);
    chk("a_drained", sb.size(), 0);
    chk("halt_pc", imem_addr, 8'h05);
    chk("halt_valid", if_valid, 0);
    chk("a_rcnt", redirect_count, 0);

    // redirect out of HALT with decode blocked: queue fills to DEPTH
    cyc(0, 0, rb_to(8'h10));
    push_stream(8'h10, 2);
    chk("r10_valid", if_valid, 0);
    chk("r10_pc", imem_addr, 8'h10);
    cyc(0, 0, 16'h0);
    chk("r10_valid2", if_valid, 1);
    repeat (4) cyc(0, 0, 16'h0);
    chk("full_pc", imem_addr, 8'h12);
    chk("full_head", if_output, word(8'h10));

    // redirect with two entries queued flushes them
    cyc(0, 0, rb_to(8'h40));
    push_stream(8'h40, 6);
    chk("r40_valid", if_valid, 0);
    chk("r40_pc", imem_addr, 8'h40);
    chk("r40_rcnt", redirect_count, 2);
    cyc(0, 0, 16'h0);
    chk("r40_valid2", if_valid, 1);
    chk("r40_head", if_output, word(8'h40));

    // redirect + stall + handshake in one cycle; new stream wraps 0xFF -> 0x00
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (if_valid && if_output[7:0] == 8'h41) begin
        found = 1;
        cyc(1, 1, rb_to(8'hFE));
        push_stream(8'hFE, 8);
      end else begin
        cyc(1, 0, 16'h0);
      end
    end
    chk("hit_41", found, 1);
    chk("rfe_valid", if_valid, 0);
    chk("rfe_pc", imem_addr, 8'hFE);
    chk("rfe_rcnt", redirect_count, 3);
    repeat (12) cyc(1, 0, 16'h0);
    chk("wrap_drained", sb.size(), 0);
    chk("wrap_halt_pc", imem_addr, 8'h05);

    // stall freezes PC and blocks enqueue
    cyc(1, 0, rb_to(8'h20));
    push_stream(8'h20, 5);
    chk("r20_pc", imem_addr, 8'h20);
    cyc(1, 1, 16'h0);
    chk("stall_pc1", imem_addr, 8'h20);
    chk("stall_valid1", if_valid, 0);
    cyc(1, 1, 16'h0);
    chk("stall_pc2", imem_addr, 8'h20);
    chk("stall_valid2", if_valid, 0);
    cyc(1, 0, 16'h0);
    chk("unstall_pc", imem_addr, 8'h21);
    repeat (10) cyc(1, 0, 16'h0);
    chk("s_drained", sb.size(), 0);
    chk("s_halt_pc", imem_addr, 8'h24);

    // reset while HALT with a full queue
    cyc(0, 0, rb_to(8'h2E));
    repeat (4) cyc(0, 0, 16'h0);
    chk("hf_valid", if_valid, 1);
    chk("hf_pc", imem_addr, 8'h2F);
    chk("hf_head", if_output, word(8'h2E));
    chk("hf_rcnt", redirect_count, 5);
    rst = 1'b1;
    cyc(0, 0, 16'h0);
    chk("mrst_valid", if_valid, 0);
    chk("mrst_out", if_output, 0);
    chk("mrst_pc", imem_addr, 0);
    chk("mrst_rcnt", redirect_count, 0);
    rst = 1'b0;
    push_stream(8'h00, 6);
    cyc(1, 0, 16'h0);
    chk("mrst_boot_pc", imem_addr, 0);
    chk("mrst_boot_valid", if_valid, 0);
    repeat (12) cyc(1, 0, 16'h0);
    chk("m_drained", sb.size(), 0);

    // redirect counter saturation
    repeat (254) cyc(0, 0, rb_to(8'h30));
    chk("rcnt_254", redirect_count, 254);
    repeat (6) cyc(0, 0, rb_to(8'h30));
    chk("rcnt_sat", redirect_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
